// File: rtl/sf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sf_pkg
//  Description : Shared screen geometry, action encoding and player state
//                enumeration used by the player sequencer and the renderer.
//  Revision    : 1.0 - initial release
// ============================================================================
package sf_pkg;

    localparam int SCREEN_W = 640;
    localparam int SPRITE_W = 128;
    localparam int SPRITE_H = 128;
    localparam int Y_GROUND = 394 - SPRITE_H;   // top-left y of a grounded sprite

    // Bit positions inside the one-hot action word
    localparam int ACT_W     = 7;
    localparam int ACT_IDLE  = 0;
    localparam int ACT_WALK  = 1;
    localparam int ACT_JUMP  = 2;
    localparam int ACT_PUNCH = 3;
    localparam int ACT_KICK  = 4;
    localparam int ACT_BLOCK = 5;
    localparam int ACT_HIT   = 6;

    localparam logic [ACT_W-1:0] ACT_OH_IDLE  = 7'b0000001;
    localparam logic [ACT_W-1:0] ACT_OH_WALK  = 7'b0000010;
    localparam logic [ACT_W-1:0] ACT_OH_JUMP  = 7'b0000100;
    localparam logic [ACT_W-1:0] ACT_OH_PUNCH = 7'b0001000;
    localparam logic [ACT_W-1:0] ACT_OH_KICK  = 7'b0010000;
    localparam logic [ACT_W-1:0] ACT_OH_BLOCK = 7'b0100000;
    localparam logic [ACT_W-1:0] ACT_OH_HIT   = 7'b1000000;

    // Encodings match the action bit indices above
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WALK  = 3'd1,
        ST_JUMP  = 3'd2,
        ST_PUNCH = 3'd3,
        ST_KICK  = 3'd4,
        ST_BLOCK = 3'd5,
        ST_HIT   = 3'd6
    } state_t;

    function automatic logic [ACT_W-1:0] state_onehot(input state_t s);
        logic [ACT_W-1:0] oh;
        case (s)
            ST_WALK:  oh = ACT_OH_WALK;
            ST_JUMP:  oh = ACT_OH_JUMP;
            ST_PUNCH: oh = ACT_OH_PUNCH;
            ST_KICK:  oh = ACT_OH_KICK;
            ST_BLOCK: oh = ACT_OH_BLOCK;
            ST_HIT:   oh = ACT_OH_HIT;
            default:  oh = ACT_OH_IDLE;
        endcase
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/player_motion.sv
`default_nettype none
// ============================================================================
//  Module      : player_motion
//  Description : Combinational per-frame position/velocity update with screen
//                clamping and ground detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module player_motion #(
    parameter int X_MAX     = 512,
    parameter int Y_GROUND  = 266,
    parameter int WALK_STEP = 4,
    parameter int GRAVITY   = 1
) (
    input  sf_pkg::state_t     state,
    input  logic               left,
    input  logic               right,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic signed [10:0] vel,
    output logic [9:0]         x_nxt,
    output logic [9:0]         y_nxt,
    output logic signed [10:0] vel_nxt,
    output logic               landed
);

    localparam logic signed [11:0] c_x_max = 12'(X_MAX);
    localparam logic signed [11:0] c_y_gnd = 12'(Y_GROUND);
    localparam logic signed [11:0] c_step  = 12'(WALK_STEP);

    logic signed [11:0] w_nx;
    logic signed [11:0] w_ny;
    logic               w_h_en;
    logic               w_v_act;

    // Horizontal step while walking or airborne, clamped to the screen
    always_comb begin
        w_h_en = (state == sf_pkg::ST_WALK) || (state == sf_pkg::ST_JUMP);
        w_nx   = $signed({2'b00, x});
        if (w_h_en && (left ^ right)) begin
            if (left) w_nx = w_nx - c_step;
            else      w_nx = w_nx + c_step;
        end
        if (w_nx < 12'sd0)         x_nxt = '0;
        else if (w_nx > c_x_max)   x_nxt = c_x_max[9:0];
        else                       x_nxt = w_nx[9:0];
    end

    // Ballistic vertical update; ground contact zeroes the velocity
    always_comb begin
        w_v_act = ($signed({2'b00, y}) < c_y_gnd) || (vel != 11'sd0);
        w_ny    = $signed({2'b00, y}) + $signed({vel[10], vel});
        y_nxt   = y;
        vel_nxt = vel;
        landed  = 1'b0;
        if (w_v_act) begin
            if (w_ny >= c_y_gnd) begin
                y_nxt   = c_y_gnd[9:0];
                vel_nxt = '0;
                landed  = 1'b1;
            end else begin
                vel_nxt = vel + 11'(GRAVITY);
                y_nxt   = (w_ny < 12'sd0) ? 10'd0 : w_ny[9:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/player_action_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : player_action_ctrl
//  Description : Per-player move/jump/attack/block/hit sequencer producing the
//                sprite position and one-hot action, updated once per frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module player_action_ctrl #(
    parameter int PLAYER_NUM   = 1,
    parameter int X_INIT_P1    = 100,
    parameter int X_INIT_P2    = 412,
    parameter int Y_GROUND     = sf_pkg::Y_GROUND,
    parameter int X_MAX        = 512,
    parameter int WALK_STEP    = 4,
    parameter int JUMP_VEL     = 12,
    parameter int GRAVITY      = 1,
    parameter int PUNCH_FRAMES = 12,
    parameter int KICK_FRAMES  = 16,
    parameter int HIT_FRAMES   = 20,
    parameter int STRIKE_FRAME = 6
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_punch,
    input  logic       btn_kick,
    input  logic       btn_block,
    input  logic       hit,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [6:0] action,
    output logic       attack_active,
    output logic       hit_taken
);

    import sf_pkg::*;

    localparam logic [9:0]         c_x_init   = (PLAYER_NUM == 2) ? 10'(X_INIT_P2) : 10'(X_INIT_P1);
    localparam logic [9:0]         c_y_gnd    = 10'(Y_GROUND);
    localparam logic signed [10:0] c_jump_vel = 11'(-JUMP_VEL);
    localparam logic [7:0]         c_strike   = 8'(STRIKE_FRAME);

    state_t             r_state;
    state_t             w_mstate;
    state_t             w_state_nxt;
    logic [9:0]         r_x;
    logic [9:0]         r_y;
    logic signed [10:0] r_vel;
    logic [7:0]         r_cnt;
    logic               r_hit_pend;
    logic               r_attack;
    logic               r_hit_taken;

    logic               w_pend;
    logic               w_accept;
    logic               w_airborne;
    logic [7:0]         w_dur;
    logic [7:0]         w_cnt_nxt;
    logic signed [10:0] w_vel_in;
    logic [9:0]         w_x_nxt;
    logic [9:0]         w_y_nxt;
    logic signed [10:0] w_vel_nxt;
    logic               w_landed;
    logic               w_attack_nxt;

    // Action decision by priority; w_mstate is the state before landing resolves
    always_comb begin
        w_pend     = r_hit_pend | hit;
        w_accept   = 1'b0;
        w_mstate   = r_state;
        w_vel_in   = r_vel;
        w_cnt_nxt  = r_cnt;
        w_airborne = (r_y < c_y_gnd) || (r_vel != 11'sd0);
        case (r_state)
            ST_PUNCH: w_dur = 8'(PUNCH_FRAMES);
            ST_KICK:  w_dur = 8'(KICK_FRAMES);
            default:  w_dur = 8'(HIT_FRAMES);
        endcase
        if (w_pend && (r_state != ST_BLOCK) && (r_state != ST_HIT)) begin
            w_accept  = 1'b1;
            w_mstate  = ST_HIT;
            w_cnt_nxt = '0;
        end else if ((r_state == ST_PUNCH) || (r_state == ST_KICK) || (r_state == ST_HIT)) begin
            if (r_cnt == w_dur - 8'd1) begin
                // Finishing mid-air hands over to JUMP so the fall continues
                w_mstate  = w_airborne ? ST_JUMP : ST_IDLE;
                w_cnt_nxt = '0;
            end else begin
                w_cnt_nxt = r_cnt + 8'd1;
            end
        end else if (r_state != ST_JUMP) begin
            w_cnt_nxt = '0;
            if (btn_block)                 w_mstate = ST_BLOCK;
            else if (btn_punch)            w_mstate = ST_PUNCH;
            else if (btn_kick)             w_mstate = ST_KICK;
            else if (btn_up) begin
                w_mstate = ST_JUMP;
                w_vel_in = c_jump_vel;
            end
            else if (btn_left ^ btn_right) w_mstate = ST_WALK;
            else                           w_mstate = ST_IDLE;
        end
    end

    player_motion #(
        .X_MAX     (X_MAX),
        .Y_GROUND  (Y_GROUND),
        .WALK_STEP (WALK_STEP),
        .GRAVITY   (GRAVITY)
    ) u_motion (
        .state   (w_mstate),
        .left    (btn_left),
        .right   (btn_right),
        .x       (r_x),
        .y       (r_y),
        .vel     (w_vel_in),
        .x_nxt   (w_x_nxt),
        .y_nxt   (w_y_nxt),
        .vel_nxt (w_vel_nxt),
        .landed  (w_landed)
    );

    // Landing ends a jump; strike flag follows the post-tick frame count
    always_comb begin
        w_state_nxt  = (w_mstate == ST_JUMP && w_landed) ? ST_IDLE : w_mstate;
        w_attack_nxt = ((w_state_nxt == ST_PUNCH) || (w_state_nxt == ST_KICK)) &&
                       (w_cnt_nxt == c_strike);
    end

    // Frame-rate state register; hits between ticks are latched until the next tick
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state     <= ST_IDLE;
            r_x         <= c_x_init;
            r_y         <= c_y_gnd;
            r_vel       <= '0;
            r_cnt       <= '0;
            r_hit_pend  <= 1'b0;
            r_attack    <= 1'b0;
            r_hit_taken <= 1'b0;
        end else begin
            r_hit_taken <= 1'b0;
            if (frame_tick) begin
                r_state     <= w_state_nxt;
                r_x         <= w_x_nxt;
                r_y         <= w_y_nxt;
                r_vel       <= w_vel_nxt;
                r_cnt       <= w_cnt_nxt;
                r_hit_pend  <= 1'b0;
                r_attack    <= w_attack_nxt;
                r_hit_taken <= w_accept;
            end else if (hit) begin
                r_hit_pend  <= 1'b1;
            end
        end
    end

    assign pos_x         = r_x;
    assign pos_y         = r_y;
    assign action        = state_onehot(r_state);
    assign attack_active = r_attack;
    assign hit_taken     = r_hit_taken;

endmodule
`default_nettype wire
